// File: rtl/aurora_rx_frame_filter_pkg.sv
// Shared definitions for the Aurora receive frame filter: write-FSM encoding,
// tuser CRC flag positions, buffer word layout and a saturating counter helper.
package aurora_rx_frame_filter_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned KEEP_W        = 4;
    localparam int unsigned USER_W        = 8;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned CRC_PASS_BIT  = 0;
    localparam int unsigned CRC_VALID_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    // One buffered beat: data, byte enables and end-of-frame marker (37 bits)
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != {CNT_W{1'b1}})) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/frameBufferRam.sv
// Simple dual-port frame buffer with registered read port; maps onto block RAM.
// Read data holds its value on cycles without a read enable.
module frameBufferRam #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned WIDTH      = 37
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/aurora_rx_frame_filter.sv
// Store-and-forward Aurora RX filter: buffers each frame speculatively and only
// releases it to the AXI-stream master once its tlast beat passes the CRC check.
module aurora_rx_frame_filter
    import aurora_rx_frame_filter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter string       CRC_CHECK  = "true"
) (
    input  logic              auUserClk,
    input  logic              auUserReset,
    input  logic [DATA_W-1:0] sAxiTdata,
    input  logic [KEEP_W-1:0] sAxiTkeep,
    input  logic [USER_W-1:0] sAxiTuser,
    input  logic              sAxiTlast,
    input  logic              sAxiTvalid,
    output logic [DATA_W-1:0] mAxiTdata,
    output logic [KEEP_W-1:0] mAxiTkeep,
    output logic              mAxiTlast,
    output logic              mAxiTvalid,
    input  logic              mAxiTready,
    output logic [CNT_W-1:0]  goodFrames,
    output logic [CNT_W-1:0]  crcDrops,
    output logic [CNT_W-1:0]  ovfDrops,
    output logic              dropPulse
);

    localparam int unsigned PW     = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam bit          CRC_EN = (CRC_CHECK != "false");

    wr_state_e state, state_nxt;

    logic [PW-1:0] rd_ptr, commit_ptr, spec_ptr;
    logic          full_c, crc_ok_c;
    logic          wr_en_c, commit_c, rewind_c, crc_drop_c, ovf_drop_c;
    logic          rd_en_c, load_out_c, rd_vld;
    logic [BEAT_W-1:0] rd_word;
    beat_t         wr_beat, rd_beat, out_beat;
    logic          out_vld;
    logic [CNT_W-1:0] good_cnt, crc_cnt, ovf_cnt;
    logic          drop_q;
    logic          unused_tuser;

    assign unused_tuser = ^sAxiTuser[USER_W-1:2];

    // Occupancy includes the uncommitted tail of the frame being received
    assign full_c   = ((spec_ptr - rd_ptr) == PW'(DEPTH));
    assign crc_ok_c = !CRC_EN || (sAxiTuser[CRC_VALID_BIT] && sAxiTuser[CRC_PASS_BIT]);

    // Write FSM: state register
    always_ff @(posedge auUserClk or posedge auUserReset) begin
        if (auUserReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (sAxiTvalid && !sAxiTlast) begin
                    state_nxt = full_c ? ST_DROP : ST_RECV;
                end
            end
            ST_RECV: begin
                if (sAxiTvalid) begin
                    if (sAxiTlast) begin
                        state_nxt = ST_IDLE;
                    end else if (full_c) begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (sAxiTvalid && sAxiTlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write FSM: per-beat actions (DROP discards everything, CRC flags included)
    always_comb begin
        wr_en_c    = 1'b0;
        commit_c   = 1'b0;
        rewind_c   = 1'b0;
        crc_drop_c = 1'b0;
        ovf_drop_c = 1'b0;
        if (sAxiTvalid && (state != ST_DROP)) begin
            if (full_c) begin
                rewind_c   = 1'b1;
                ovf_drop_c = 1'b1;
            end else begin
                wr_en_c = 1'b1;
                if (sAxiTlast) begin
                    if (crc_ok_c) begin
                        commit_c = 1'b1;
                    end else begin
                        rewind_c   = 1'b1;
                        crc_drop_c = 1'b1;
                    end
                end
            end
        end
    end

    assign wr_beat = '{data: sAxiTdata, keep: sAxiTkeep, last: sAxiTlast};

    // Write-side pointers
    always_ff @(posedge auUserClk or posedge auUserReset) begin
        if (auUserReset) begin
            spec_ptr   <= '0;
            commit_ptr <= '0;
        end else begin
            if (rewind_c) begin
                spec_ptr <= commit_ptr;
            end else if (wr_en_c) begin
                spec_ptr <= spec_ptr + PW'(1);
            end
            if (commit_c) begin
                commit_ptr <= spec_ptr + PW'(1);
            end
        end
    end

    frameBufferRam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (BEAT_W)
    ) u_frame_buffer_ram (
        .clk     (auUserClk),
        .wr_en   (wr_en_c),
        .wr_addr (spec_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_beat),
        .rd_en   (rd_en_c),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

    assign rd_beat = beat_t'(rd_word);

    // RAM output acts as a one-deep stage; it is refilled only when drained
    assign load_out_c = rd_vld && (!out_vld || mAxiTready);
    assign rd_en_c    = (rd_ptr != commit_ptr) && (!rd_vld || load_out_c);

    always_ff @(posedge auUserClk or posedge auUserReset) begin
        if (auUserReset) begin
            rd_ptr   <= '0;
            rd_vld   <= 1'b0;
            out_vld  <= 1'b0;
            out_beat <= '0;
        end else begin
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (rd_en_c) begin
                rd_vld <= 1'b1;
            end else if (load_out_c) begin
                rd_vld <= 1'b0;
            end
            if (load_out_c) begin
                out_vld  <= 1'b1;
                out_beat <= rd_beat;
            end else if (mAxiTready) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign mAxiTvalid = out_vld;
    assign mAxiTdata  = out_beat.data;
    assign mAxiTkeep  = out_beat.keep;
    assign mAxiTlast  = out_beat.last;

    // Saturating event counters and drop strobe
    always_ff @(posedge auUserClk or posedge auUserReset) begin
        if (auUserReset) begin
            good_cnt <= '0;
            crc_cnt  <= '0;
            ovf_cnt  <= '0;
            drop_q   <= 1'b0;
        end else begin
            good_cnt <= sat_inc(good_cnt, commit_c);
            crc_cnt  <= sat_inc(crc_cnt, crc_drop_c);
            ovf_cnt  <= sat_inc(ovf_cnt, ovf_drop_c);
            drop_q   <= crc_drop_c || ovf_drop_c;
        end
    end

    assign goodFrames = good_cnt;
    assign crcDrops   = crc_cnt;
    assign ovfDrops   = ovf_cnt;
    assign dropPulse  = drop_q;

endmodule

// File: tb/tb_aurora_rx_frame_filter.sv
// Self-checking bench for aurora_rx_frame_filter (16-word buffer, CRC checking on).
// Committed frames are queued as expected output words and matched as they leave.
module tb_aurora_rx_frame_filter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        int          len;
        logic [7:0]  user;
        bit          good;
        logic [15:0] e_good;
        logic [15:0] e_crc;
        logic [15:0] e_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sAxiTdata = '0;
    logic [3:0]  sAxiTkeep = '0;
    logic [7:0]  sAxiTuser = '0;
    logic        sAxiTlast = 1'b0;
    logic        sAxiTvalid = 1'b0;
    logic [31:0] mAxiTdata;
    logic [3:0]  mAxiTkeep;
    logic        mAxiTlast;
    logic        mAxiTvalid;
    logic        mAxiTready = 1'b1;
    logic [15:0] goodFrames, crcDrops, ovfDrops;
    logic        dropPulse;

    int    checks = 0;
    int    errors = 0;
    int    drop_seen = 0;
    int    e_drops = 0;
    logic [15:0] e_good = '0, e_crc = '0, e_ovf = '0;
    bit    tog_en = 1'b0;
    word_t sb[$];
    vec_t  vecs[10];

    aurora_rx_frame_filter #(
        .ADDR_WIDTH (4),
        .CRC_CHECK  ("true")
    ) dut (
        .auUserClk   (clk),
        .auUserReset (rst),
        .sAxiTdata   (sAxiTdata),
        .sAxiTkeep   (sAxiTkeep),
        .sAxiTuser   (sAxiTuser),
        .sAxiTlast   (sAxiTlast),
        .sAxiTvalid  (sAxiTvalid),
        .mAxiTdata   (mAxiTdata),
        .mAxiTkeep   (mAxiTkeep),
        .mAxiTlast   (mAxiTlast),
        .mAxiTvalid  (mAxiTvalid),
        .mAxiTready  (mAxiTready),
        .goodFrames  (goodFrames),
        .crcDrops    (crcDrops),
        .ovfDrops    (ovfDrops),
        .dropPulse   (dropPulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every valid cycle must show the head of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (dropPulse) drop_seen++;
            if (mAxiTvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", mAxiTdata, 32'hDEAD_DEAD);
                end else begin
                    chk("out_data", mAxiTdata, sb[0].data);
                    chk("out_keep", 32'(mAxiTkeep), 32'(sb[0].keep));
                    chk("out_last", 32'(mAxiTlast), 32'(sb[0].last));
                    if (mAxiTready) void'(sb.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_en) mAxiTready = ~mAxiTready;
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [7:0] u);
        sAxiTdata  = d;
        sAxiTkeep  = k;
        sAxiTlast  = l;
        sAxiTuser  = u;
        sAxiTvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input logic [7:0] user, input bit push);
        for (int i = 0; i < len; i++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            d = $urandom();
            l = (i == len - 1);
            k = l ? 4'h7 : 4'hF;
            if (push) sb.push_back(word_t'{data: d, keep: k, last: l});
            send_beat(d, k, l, l ? user : 8'h03);
        end
        sAxiTvalid = 1'b0;
        sAxiTlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        mAxiTready = 1'b1;
        while ((sb.size() != 0 || mAxiTvalid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < 300), 32'd1);
        idle(3);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_goodFrames"}, 32'(goodFrames), 32'(e_good));
        chk({tag, "_crcDrops"}, 32'(crcDrops), 32'(e_crc));
        chk({tag, "_ovfDrops"}, 32'(ovfDrops), 32'(e_ovf));
        chk({tag, "_dropPulses"}, 32'(drop_seen), 32'(e_drops));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        // {len, tuser on tlast, committed, goodFrames, crcDrops, ovfDrops}
        vecs[0] = '{4,  8'h03, 1'b1, 16'd1, 16'd0, 16'd0};
        vecs[1] = '{3,  8'h02, 1'b0, 16'd1, 16'd1, 16'd0};
        vecs[2] = '{2,  8'h03, 1'b1, 16'd2, 16'd1, 16'd0};
        vecs[3] = '{1,  8'h01, 1'b0, 16'd2, 16'd2, 16'd0};
        vecs[4] = '{1,  8'h00, 1'b0, 16'd2, 16'd3, 16'd0};
        vecs[5] = '{20, 8'h03, 1'b0, 16'd2, 16'd3, 16'd1};
        vecs[6] = '{1,  8'h03, 1'b1, 16'd3, 16'd3, 16'd1};
        vecs[7] = '{16, 8'hFF, 1'b1, 16'd4, 16'd3, 16'd1};
        vecs[8] = '{17, 8'h03, 1'b0, 16'd4, 16'd3, 16'd2};
        vecs[9] = '{5,  8'h03, 1'b1, 16'd5, 16'd3, 16'd2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(mAxiTvalid), 32'd0);
        chk("rst_last", 32'(mAxiTlast), 32'd0);
        chk("rst_data", mAxiTdata, 32'd0);
        chk("rst_keep", 32'(mAxiTkeep), 32'd0);
        chk("rst_drop", 32'(dropPulse), 32'd0);
        rst = 1'b0;
        idle(2);
        check_counts("rst");

        // Table of single frames, each drained before the next
        foreach (vecs[i]) begin
            send_frame(vecs[i].len, vecs[i].user, vecs[i].good);
            drain($sformatf("vec%0d", i));
            e_good = vecs[i].e_good;
            e_crc  = vecs[i].e_crc;
            e_ovf  = vecs[i].e_ovf;
            if (!vecs[i].good) e_drops++;
            check_counts($sformatf("vec%0d", i));
        end

        // First word must appear exactly two cycles after the committing tlast
        for (int i = 0; i < 3; i++) begin
            d = 32'hA5A5_0000 + 32'(i);
            sb.push_back(word_t'{data: d, keep: 4'hF, last: (i == 2)});
            if (i < 2) send_beat(d, 4'hF, 1'b0, 8'h00);
        end
        sAxiTdata = 32'hA5A5_0002;
        sAxiTlast = 1'b1;
        sAxiTuser = 8'h03;
        @(posedge clk);
        #1;
        sAxiTvalid = 1'b0;
        sAxiTlast  = 1'b0;
        chk("lat_edge0_valid", 32'(mAxiTvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge1_valid", 32'(mAxiTvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", 32'(mAxiTvalid), 32'd1);
        drain("lat");
        e_good++;
        check_counts("lat");

        // Two back-to-back 8-word frames with ready toggling every cycle
        tog_en = 1'b1;
        send_frame(8, 8'h03, 1'b1);
        send_frame(8, 8'h03, 1'b1);
        idle(10);
        tog_en = 1'b0;
        drain("b2b");
        e_good += 16'd2;
        check_counts("b2b");

        // Fill the buffer while stalled, overflow at the exact limit, then
        // write behind the drain using space freed one cycle earlier
        mAxiTready = 1'b0;
        send_frame(16, 8'h03, 1'b1);
        idle(3);
        send_frame(2, 8'h03, 1'b1);
        send_frame(1, 8'h03, 1'b0);
        idle(2);
        mAxiTready = 1'b1;
        idle(1);
        send_frame(8, 8'h03, 1'b1);
        drain("full");
        e_good += 16'd3;
        e_ovf++;
        e_drops++;
        check_counts("full");

        // Counter saturation
        force dut.crc_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.crc_cnt;
        idle(1);
        send_frame(2, 8'h01, 1'b0);
        drain("sat");
        e_crc = 16'hFFFF;
        e_drops++;
        check_counts("sat");

        // Reset mid-frame discards committed and partial data
        mAxiTready = 1'b0;
        send_frame(3, 8'h03, 1'b1);
        for (int i = 0; i < 5; i++) send_beat($urandom(), 4'hF, 1'b0, 8'h03);
        rst = 1'b1;
        sb.delete();
        sAxiTvalid = 1'b0;
        idle(2);
        chk("midrst_valid", 32'(mAxiTvalid), 32'd0);
        e_good = '0;
        e_crc  = '0;
        e_ovf  = '0;
        check_counts("midrst");
        rst = 1'b0;
        mAxiTready = 1'b1;
        idle(1);
        send_frame(2, 8'h03, 1'b1);
        drain("postrst");
        e_good = 16'd1;
        check_counts("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_rx_frame_filter.md
AURORA_RX_FRAME_FILTER -- requirements
Module: aurora_rx_frame_filter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning log2 of the frame buffer depth in 32-bit words (DEPTH = 2^ADDR_WIDTH).
REQ-002 SHALL have parameter CRC_CHECK, default "true"; when "false", every complete frame is committed regardless of CRC flags.
REQ-003 SHALL have port auUserClk, input, 1, the single clock for all logic.
REQ-004 SHALL have port auUserReset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port sAxiTdata, input, 32, receive data word.
REQ-006 SHALL have port sAxiTkeep, input, 4, byte enables, stored with the word.
REQ-007 SHALL have port sAxiTuser, input, 8; bit0 = crcPass, bit1 = crcValid, bits 7:2 ignored.
REQ-008 SHALL have port sAxiTlast, input, 1, last beat of frame.
REQ-009 SHALL have port sAxiTvalid, input, 1, beat present; the input has no ready and cannot be stalled.
REQ-010 SHALL have ports mAxiTdata (out, 32), mAxiTkeep (out, 4), mAxiTlast (out, 1), mAxiTvalid (out, 1), mAxiTready (in, 1), a standard AXI-stream master.
REQ-011 SHALL have ports goodFrames, crcDrops, ovfDrops, each output, 16 bits, saturating event counters.
REQ-012 SHALL have port dropPulse, output, 1, a one-cycle strobe when any frame is discarded.

Function
REQ-013 SHALL be store-and-forward: no word of a frame appears on the output before that frame's tlast beat has been accepted and committed.
REQ-014 SHALL keep a read pointer, a committed write pointer and a speculative write pointer, each ADDR_WIDTH+1 bits with wrap-around modulo 2^(ADDR_WIDTH+1).
REQ-015 SHALL run a write state machine with states IDLE, RECV and DROP.
REQ-016 IDLE: on a valid beat, the machine SHALL write the beat; if tlast is set, it evaluates the frame end per REQ-018, else it moves to RECV.
REQ-017 RECV: each valid beat SHALL be written at the speculative pointer, which then increments; a beat with tlast set SHALL evaluate the frame end and return to IDLE.
REQ-018 Frame end: commit (committed pointer = speculative pointer + 1, goodFrames += 1) if CRC_CHECK == "false" or (crcValid AND crcPass) on the tlast beat; otherwise rewind the speculative pointer to the committed pointer, increment crcDrops and pulse dropPulse.
REQ-019 Overflow: a valid beat arriving while speculative pointer minus read pointer equals DEPTH SHALL NOT be written; the speculative pointer SHALL rewind, and the machine SHALL enter DROP, or stay in IDLE if that beat had tlast set; ovfDrops += 1 and dropPulse pulses once per frame.
REQ-020 DROP: all beats SHALL be discarded until a beat with tlast set, then the machine returns to IDLE; CRC flags are ignored in DROP.
REQ-021 The output SHALL present data when the read pointer differs from the committed pointer, through a registered read stage plus one output register, with first-word-fall-through behaviour.
REQ-022 With the output idle and mAxiTready high, mAxiTvalid SHALL rise exactly 2 cycles after the committing tlast beat.
REQ-023 While mAxiTready is high, the output SHALL sustain one word per cycle; output data SHALL be held stable while mAxiTvalid is high and mAxiTready is low.
REQ-024 Simultaneous read and write in the same cycle SHALL be supported; space freed by a read in cycle N SHALL be usable by a write in cycle N+1.
REQ-025 The counters SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-026 Assertion of auUserReset SHALL asynchronously clear all pointers, the state (to IDLE), mAxiTvalid, mAxiTlast, dropPulse and all counters; mAxiTdata and mAxiTkeep reset to 0.
REQ-027 Reset mid-frame SHALL discard both committed and uncommitted contents; beats arriving after deassertion SHALL start a new frame (IDLE).

Structure
REQ-028 The state encoding and the tuser bit indices (CRC_PASS_BIT = 0, CRC_VALID_BIT = 1) SHALL live in the shared cell-comm package.
REQ-029 The buffer SHALL be a sub-module frameBufferRam: simple dual-port, 37 bits wide (data + keep + last), 2^ADDR_WIDTH deep, with registered read and inferred as block RAM.

Verification (ADDR_WIDTH = 4, CRC_CHECK = "true")
REQ-030 4-word frame with tuser = 0x03 on tlast, mAxiTready = 1 -> the same 4 words are output starting 2 cycles after tlast; goodFrames = 1.
REQ-031 3-word frame with tuser = 0x02 on tlast, followed by a good 2-word frame -> only the 2-word frame is output; crcDrops = 1, one dropPulse.
REQ-032 20-word frame -> overflow at word 17, no output; ovfDrops = 1; a following good 1-word frame is output correctly.
REQ-033 Two back-to-back good 8-word frames with mAxiTready toggling 1/0 -> 16 words in order, tlast on words 8 and 16, data stable during stalls.
REQ-034 auUserReset asserted after 5 beats of an 8-word frame, then a good 2-word frame -> only the 2-word frame is output; counters read goodFrames = 1 after reset.
REQ-035 Force crcDrops to 0xFFFF, then send one bad frame -> crcDrops stays at 0xFFFF.
